sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
Shares the single SDRAM command engine between three requesters: the 68030 CPU port, a secondary bus-master (DMA) port and periodic auto-refresh. Sits between the CPU/DMA bus logic and the SDRAM sequencer. It holds a saturating backlog of refresh requests and issues one-cycle start strobes with a source select. It tracks each engine transaction to completion, with a watchdog that forces completion if the engine never finishes.

Parameters:
REF_MAX, 4, saturation limit of the pending-refresh counter; at this level a refresh is urgent.
TIMEOUT, 63, maximum cycles in BUSY before the watchdog forces completion.
STARVE_LIMIT, 3, consecutive CPU grants while DMA waits before DMA is forced (only with ARB_FAIRNESS_EN).

Ports:
CLK  in  1  SDRAM clock; all logic on its rising edge.
RESET  in  1  asynchronous, active-low reset.
READY  in  1  low = SDRAM init complete; no grants are issued while high.
REQ_CPU  in  1  CPU access request, level, held until ACK_CPU.
REQ_DMA  in  1  DMA access request, level, held until ACK_DMA.
REFRESH_TICK  in  1  refresh interval pulse; sampled on its rising edge.
ENG_DONE  in  1  one-cycle pulse from the engine: current operation finished.
ENG_START  out  1  one-cycle start strobe to the engine.
ENG_SEL  out  2  00 CPU, 01 DMA, 10 refresh; stable from ENG_START until DONE exits.
GNT_CPU  out  1  CPU owns the engine (START through BUSY).
GNT_DMA  out  1  DMA owns the engine.
ACK_CPU  out  1  one-cycle completion pulse to the CPU.
ACK_DMA  out  1  one-cycle completion pulse to the DMA port.
REF_OVF  out  1  sticky: a refresh tick was dropped at saturation.
TMO_ERR  out  1  sticky: the watchdog fired.

Behaviour:
- Reset values: ENG_START, GNT_*, ACK_*, REF_OVF and TMO_ERR are 0; ENG_SEL is 00; state is IDLE; pending counter, watchdog and starve counters are 0. Reset mid-transaction abandons it immediately with no ACK.
- Pending counter, 3 bits, saturating:
  - +1 on each REFRESH_TICK rising edge (registered edge detect).
  - -1 on ENG_DONE when ENG_SEL=10.
  - Tick and refresh-done in the same cycle: counter unchanged.
  - Tick at REF_MAX with no done: counter stays at REF_MAX and REF_OVF is set.
- FSM states: IDLE, START, BUSY, DONE.
  - IDLE: while READY=1, no selection is made. Otherwise arbitration priority is:
    1. pending = REF_MAX → refresh.
    2. REQ_CPU → CPU.
    3. REQ_DMA → DMA.
    4. pending > 0 → refresh.
    5. Otherwise stay in IDLE.
  - On a selection: ENG_SEL is registered, the matching GNT is set, and the next state is START.
  - START: ENG_START=1 for exactly this cycle; watchdog cleared; go to BUSY.
  - BUSY: watchdog increments each cycle. On ENG_DONE go to DONE. If the watchdog reaches TIMEOUT first, set TMO_ERR and go to DONE as a forced completion; the pending counter is still decremented for a refresh.
  - DONE: GNT_* cleared; the matching ACK is high for this cycle only (none for refresh); go to IDLE.
- Requester handshake: the requester drops REQ on the edge at which it samples ACK=1. That edge also moves the FSM to IDLE, so the acked request is never re-granted.
- Latency: REQ seen in IDLE gives ENG_START 1 cycle later. Minimum request-to-request spacing is 4 cycles (IDLE, START, BUSY, DONE).
- ENG_DONE outside BUSY is ignored, except for the pending-counter decrement rule. A REQ that drops while the requester is granted does not abort the transaction.

Optional Feature:
ARB_FAIRNESS_EN:
- Defined: a 2-bit starve counter increments on each CPU grant made while REQ_DMA=1, and clears on a DMA grant or whenever REQ_DMA=0. When it equals STARVE_LIMIT, DMA outranks CPU (refresh urgency still wins).
- Undefined: fixed priority as listed above; DMA can starve indefinitely.

Test Plan:
- Reset with READY=0, REQ_CPU=1 → ENG_START at cycle 2 after reset release, ENG_SEL=00; ENG_DONE 5 cycles later → ACK_CPU one cycle, GNT_CPU falls the same cycle.
- REQ_CPU and REQ_DMA both held, pending=0 → CPU served first, then DMA; ENG_SEL sequence 00, 01; no overlapping GNTs.
- 5 REFRESH_TICKs with no completions → pending=4 and REF_OVF=1. The next IDLE selects refresh (ENG_SEL=10) even with REQ_CPU=1.
- Tick coincident with a refresh ENG_DONE at pending=2 → pending stays 2.
- Grant DMA, never pulse ENG_DONE → after 63 BUSY cycles TMO_ERR=1, ACK_DMA pulses, FSM back in IDLE.
- With ARB_FAIRNESS_EN, CPU back-to-back and DMA waiting → 3 CPU grants, then DMA granted. Without the macro, DMA is never granted while REQ_CPU stays high.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM command engine between the CPU port, the DMA
// port and periodic auto-refresh. Keeps a saturating backlog of refresh ticks,
// issues one-cycle start strobes with a source select, and watches each engine
// transaction with a watchdog that forces completion if the engine hangs.
// Optional build macro: ARB_FAIRNESS_EN (DMA outranks CPU after STARVE_LIMIT
// consecutive CPU grants made while DMA was waiting).
module sdram_arbiter #(
   parameter int REF_MAX      = 4,
   parameter int TIMEOUT      = 63,
   parameter int STARVE_LIMIT = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       READY,
   input  logic       REQ_CPU,
   input  logic       REQ_DMA,
   input  logic       REFRESH_TICK,
   input  logic       ENG_DONE,
   output logic       ENG_START,
   output logic [1:0] ENG_SEL,
   output logic       GNT_CPU,
   output logic       GNT_DMA,
   output logic       ACK_CPU,
   output logic       ACK_DMA,
   output logic       REF_OVF,
   output logic       TMO_ERR
);

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   localparam logic [1:0] SEL_CPU    = 2'b00;
   localparam logic [1:0] SEL_DMA    = 2'b01;
   localparam logic [1:0] SEL_REF    = 2'b10;
   localparam logic [2:0] REF_LVL    = 3'(REF_MAX);
   localparam logic [5:0] WDOG_LAST  = 6'(TIMEOUT - 1);
   localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR_EN = 1'b1;
`else
   localparam bit FAIR_EN = 1'b0;
`endif

   state_t     state;
   state_t     state_next;
   logic [1:0] sel_next;
   logic       sel_load;
   logic [2:0] pending;
   logic       tick_q;
   logic       tick_rise;
   logic       ref_dec;
   logic [5:0] wdog;
   logic       wdog_fire;
   logic [1:0] starve;
   logic       dma_first;
   logic       cpu_grant;
   logic       dma_grant;

   assign tick_rise = REFRESH_TICK & ~tick_q;
   assign wdog_fire = (state == BUSY) && !ENG_DONE && (wdog == WDOG_LAST);
   assign ref_dec   = (ENG_SEL == SEL_REF) && (ENG_DONE || wdog_fire);
   assign dma_first = FAIR_EN && (starve == STARVE_MAX);
   assign cpu_grant = sel_load && (sel_next == SEL_CPU);
   assign dma_grant = sel_load && (sel_next == SEL_DMA);

   assign ENG_START = (state == START);
   assign GNT_CPU   = ((state == START) || (state == BUSY)) && (ENG_SEL == SEL_CPU);
   assign GNT_DMA   = ((state == START) || (state == BUSY)) && (ENG_SEL == SEL_DMA);
   assign ACK_CPU   = (state == DONE) && (ENG_SEL == SEL_CPU);
   assign ACK_DMA   = (state == DONE) && (ENG_SEL == SEL_DMA);

   // State register and the source select latched at the moment of a grant
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= IDLE;
         ENG_SEL <= SEL_CPU;
      end else begin
         state <= state_next;
         if (sel_load) ENG_SEL <= sel_next;
      end
   end

   // Arbitration and transaction sequencing
   always_comb begin
      state_next = state;
      sel_next   = ENG_SEL;
      sel_load   = 1'b0;
      case (state)
         IDLE: begin
            if (!READY) begin
               sel_load = 1'b1;
               if (pending == REF_LVL)        sel_next = SEL_REF;
               else if (REQ_DMA && dma_first) sel_next = SEL_DMA;
               else if (REQ_CPU)              sel_next = SEL_CPU;
               else if (REQ_DMA)              sel_next = SEL_DMA;
               else if (pending != 3'd0)      sel_next = SEL_REF;
               else                           sel_load = 1'b0;
               if (sel_load) state_next = START;
            end
         end
         START:   state_next = BUSY;
         BUSY:    if (ENG_DONE || wdog_fire) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Watchdog: restarted on each start strobe, counts cycles spent in BUSY
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wdog    <= 6'd0;
         TMO_ERR <= 1'b0;
      end else begin
         if (state == START)     wdog <= 6'd0;
         else if (state == BUSY) wdog <= wdog + 6'd1;
         if (wdog_fire) TMO_ERR <= 1'b1;
      end
   end

   // Refresh backlog: a tick and a refresh completion in one cycle cancel out
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         tick_q  <= 1'b0;
         pending <= 3'd0;
         REF_OVF <= 1'b0;
      end else begin
         tick_q <= REFRESH_TICK;
         if (tick_rise && !ref_dec) begin
            if (pending == REF_LVL) REF_OVF <= 1'b1;
            else                    pending <= pending + 3'd1;
         end else if (ref_dec && !tick_rise && pending != 3'd0) begin
            pending <= pending - 3'd1;
         end
      end
   end

   // Starvation tracking: counts CPU wins while DMA is kept waiting
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         starve <= 2'd0;
      end else if (!REQ_DMA || dma_grant) begin
         starve <= 2'd0;
      end else if (cpu_grant && starve != STARVE_MAX) begin
         starve <= starve + 2'd1;
      end
   end

endmodule
